osd_msg_ctrl: RTL and testbench
===============================

OSD_MSG_CTRL -- requirements
Module: osd_msg_ctrl

Interface
REQ-001 Parameter SCREEN_COLS, default 32, characters per OSD row; SHALL be a power of two.
REQ-002 Parameter SCREEN_ROWS, default 32, character rows; SHALL be a power of two; SCREEN_COLS*SCREEN_ROWS <= 2048.
REQ-003 Parameter BLANK_CHAR, default 8'h20, code written during screen clear.
REQ-004 Parameter DISPLAY_FRAMES, default 180, frames osd_active stays high; 0 = until cancel.
REQ-005 clk  in  1  master clock; sole clock domain.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 vblank  in  1  vertical blank from video timing, synchronous to clk.
REQ-008 req_valid  in  1  message display request.
REQ-009 req_msg_id  in  4  message number; sampled on handshake.
REQ-010 req_ready  out  1  high when a request can be accepted.
REQ-011 cancel  in  1  abort display and return to idle.
REQ-012 rom_addr  out  12  message ROM address {msg_id, idx[7:0]}.
REQ-013 rom_data  in  8  message ROM data, valid exactly 1 cycle after rom_addr.
REQ-014 ram_we  out  1  character RAM write strobe.
REQ-015 ram_addr  out  11  character RAM write address.
REQ-016 ram_data  out  8  character code to write.
REQ-017 osd_active  out  1  overlay enable for the overlay renderer.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 States: IDLE, CLEAR, HDR_ROW, HDR_COL, COPY, SHOW.
REQ-020 Handshake: request accepted on a cycle with req_valid & req_ready; req_ready = (state==IDLE | state==SHOW) & ~cancel.
REQ-021 Accept -> CLEAR; msg_id latched; osd_active low from next cycle; frame counter zeroed.
REQ-022 CLEAR: one write per cycle of BLANK_CHAR to addresses 0..SCREEN_COLS*SCREEN_ROWS-1 ascending; after last write -> HDR_ROW.
REQ-023 Message format: byte 0 = start row, byte 1 = start column, bytes 2..255 = character codes, 8'h00 terminates.
REQ-024 HDR_ROW/HDR_COL: fetch bytes 0 and 1 honouring 1-cycle ROM latency; row taken modulo SCREEN_ROWS, column modulo SCREEN_COLS.
REQ-025 COPY: ROM reads pipelined, sustaining one RAM write per cycle after the first character; ram_addr = row*SCREEN_COLS+col.
REQ-026 Cursor advance: col+1; col wraps to 0 with row+1; row wraps from SCREEN_ROWS-1 to 0.
REQ-027 COPY ends on 8'h00 (not written) or after byte 255 is written; -> SHOW.
REQ-028 ram_we SHALL be high only in CLEAR and COPY; no write beyond terminator.
REQ-029 SHOW: osd_active=1; each vblank rising edge (0->1) increments frame counter; counter reaching DISPLAY_FRAMES -> IDLE, osd_active low next cycle.
REQ-030 DISPLAY_FRAMES=0: SHOW persists until cancel or new request.
REQ-031 New request accepted in SHOW restarts at CLEAR (REQ-021).
REQ-032 Request in CLEAR/HDR/COPY: req_ready low; request held by requester, not lost or queued internally.
REQ-033 cancel in any state: next state IDLE, ram_we and osd_active low next cycle; in-progress write sequence abandoned; cancel wins over simultaneous req_valid.
REQ-034 vblank edge detector SHALL use registered previous value; vblank high on entry to SHOW does not count as an edge.

Reset
REQ-035 On reset: state IDLE, osd_active=0, ram_we=0, ram_addr=0, ram_data=0, rom_addr=0, busy=0, req_ready=1 after release, counters 0.
REQ-036 Reset asserted mid-operation SHALL abort immediately with no further RAM writes; RAM contents are not cleared by reset.

Verification
REQ-037 Msg 3 = {row 2, col 5, "HI", 00}: accept -> 1024 writes of 8'h20, then 'H'@69, 'I'@70, no write to 71; osd_active high; after 180 vblank rising edges osd_active=0, busy=0.
REQ-038 Msg {row 31, col 31, "AB", 00}: 'A'@1023, 'B'@0 (wrap).
REQ-039 Message of 254 non-zero chars, no terminator: exactly 254 COPY writes, then SHOW.
REQ-040 req_valid during COPY: req_ready=0, no accept; req_valid during SHOW with msg 1: restart, CLEAR writes resume from address 0.
REQ-041 cancel asserted mid-CLEAR at address 500, same cycle as req_valid: no write after that cycle, state IDLE, request not accepted.
REQ-042 Async reset pulse mid-COPY between clk edges: outputs reach reset values without a clock edge; DISPLAY_FRAMES=0 run stays in SHOW for 1000 frames until cancel.

Source files
------------

// File: rtl/osd_msg_ctrl.sv
// osd_msg_ctrl: clears the OSD character RAM, copies a ROM message into it at its
// start cursor, then keeps the overlay active for a number of vblank frames.
module osd_msg_ctrl #(
  parameter int SCREEN_COLS = 32,
  parameter int SCREEN_ROWS = 32,
  parameter logic [7:0] BLANK_CHAR = 8'h20,
  parameter int DISPLAY_FRAMES = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblank,
  input  logic        req_valid,
  input  logic [3:0]  req_msg_id,
  output logic        req_ready,
  input  logic        cancel,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        ram_we,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        osd_active,
  output logic        busy
);
  localparam int CW = $clog2(SCREEN_COLS);
  localparam int RW = $clog2(SCREEN_ROWS);
  localparam int AW = CW + RW;
  typedef enum logic [2:0] {IDLE, CLEAR, HDR_ROW, HDR_COL, COPY, SHOW} state_t;
  state_t state_q, state_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic [AW-1:0] pos_q, pos_d;
  logic [15:0] frame_q, frame_d;
  logic vb_q, osd_q, osd_d, vb_rise;
  logic [7:0] wdata;
  // rom_addr always runs one byte ahead of rom_data; the cursor {row,col} wraps naturally
  always_comb begin
    state_d = state_q;
    rom_addr_d = rom_addr_q;
    pos_d = pos_q;
    frame_d = frame_q;
    ram_we = 1'b0;
    wdata = BLANK_CHAR;
    vb_rise = vblank && !vb_q;
    req_ready = (state_q == IDLE || state_q == SHOW) && !cancel;
    case (state_q)
      CLEAR: begin
        ram_we = 1'b1;
        pos_d = pos_q + 1'b1;
        if (&pos_q) begin
          state_d = HDR_ROW;
          rom_addr_d[7:0] = 8'd1;
        end
      end
      HDR_ROW: begin
        pos_d = {rom_data[RW-1:0], pos_q[CW-1:0]};
        rom_addr_d[7:0] = rom_addr_q[7:0] + 8'd1;
        state_d = HDR_COL;
      end
      HDR_COL: begin
        pos_d = {pos_q[AW-1:CW], rom_data[CW-1:0]};
        rom_addr_d[7:0] = rom_addr_q[7:0] + 8'd1;
        state_d = COPY;
      end
      COPY: begin
        rom_addr_d[7:0] = rom_addr_q[7:0] + 8'd1;
        if (rom_data == 8'd0) state_d = SHOW;
        else begin
          ram_we = 1'b1;
          wdata = rom_data;
          pos_d = pos_q + 1'b1;
          if (rom_addr_q[7:0] == 8'd0) state_d = SHOW;
        end
      end
      SHOW: begin
        if (vb_rise) begin
          frame_d = frame_q + 16'd1;
          if (DISPLAY_FRAMES != 0 && frame_d == 16'(DISPLAY_FRAMES)) state_d = IDLE;
        end
      end
      default: ;
    endcase
    if (req_valid && req_ready) begin
      state_d = CLEAR;
      rom_addr_d = {req_msg_id, 8'd0};
      pos_d = '0;
      frame_d = 16'd0;
    end
    if (cancel) state_d = IDLE;
    osd_d = state_d == SHOW;
    ram_addr = ram_we ? 11'(pos_q) : 11'd0;
    ram_data = ram_we ? wdata : 8'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rom_addr_q <= 12'd0;
      pos_q <= '0;
      frame_q <= 16'd0;
      vb_q <= 1'b0;
      osd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rom_addr_q <= rom_addr_d;
      pos_q <= pos_d;
      frame_q <= frame_d;
      vb_q <= vblank;
      osd_q <= osd_d;
    end
  end
  assign rom_addr = rom_addr_q;
  assign osd_active = osd_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_osd_msg_ctrl.sv
// tb_osd_msg_ctrl: directed bench for osd_msg_ctrl with a ROM/RAM model,
// a default 32x32 instance and a 4x4 instance that shows until cancel.
module tb_osd_msg_ctrl;
  logic clk = 1'b0, reset = 1'b1, vblank = 1'b0, req_valid = 1'b0, cancel = 1'b0;
  logic [3:0] req_msg_id = 4'd0;
  logic req_ready, ram_we, osd_active, busy;
  logic [11:0] rom_addr;
  logic [7:0] rom_data = 8'd0, ram_data;
  logic [10:0] ram_addr;
  logic b_vblank = 1'b0, b_req_valid = 1'b0, b_cancel = 1'b0;
  logic [3:0] b_req_msg_id = 4'd0;
  logic b_req_ready, b_ram_we, b_osd_active, b_busy;
  logic [11:0] b_rom_addr;
  logic [7:0] b_rom_data = 8'd0, b_ram_data;
  logic [10:0] b_ram_addr;
  logic [7:0] rom [0:4095];
  logic [7:0] ram [0:2047];
  logic [7:0] bram [0:2047];
  logic [10:0] blank_next = 11'd0;
  int errors = 0, checks = 0, n_blank = 0, n_char = 0, nw = 0, bad_order = 0, b_nw = 0;

  osd_msg_ctrl dut (
    .clk(clk), .reset(reset), .vblank(vblank), .req_valid(req_valid), .req_msg_id(req_msg_id),
    .req_ready(req_ready), .cancel(cancel), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .osd_active(osd_active), .busy(busy)
  );
  osd_msg_ctrl #(.SCREEN_COLS(4), .SCREEN_ROWS(4), .DISPLAY_FRAMES(0)) dut_b (
    .clk(clk), .reset(reset), .vblank(b_vblank), .req_valid(b_req_valid), .req_msg_id(b_req_msg_id),
    .req_ready(b_req_ready), .cancel(b_cancel), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_data(b_ram_data), .osd_active(b_osd_active), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    b_rom_data <= rom[b_rom_addr];
  end
  always @(posedge clk) if (ram_we) begin
    ram[ram_addr] <= ram_data;
    nw <= nw + 1;
    if (ram_data == 8'h20) begin
      n_blank <= n_blank + 1;
      if (ram_addr != 11'd0 && ram_addr != blank_next) bad_order <= bad_order + 1;
      blank_next <= ram_addr + 11'd1;
    end else n_char <= n_char + 1;
  end
  always @(posedge clk) if (b_ram_we) begin
    bram[b_ram_addr] <= b_ram_data;
    b_nw <= b_nw + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] id);
    @(negedge clk);
    req_valid = 1'b1;
    req_msg_id = id;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_osd(input logic v, input string tag);
    int n = 0;
    while (osd_active !== v && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(osd_active), 32'(v));
  endtask

  task automatic wait_char(input int base);
    int n = 0;
    while (n_char == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("copy_start", 32'(n_char != base), 32'd1);
  endtask

  task automatic vb_pulse();
    @(negedge clk);
    vblank = 1'b1;
    repeat (2) @(negedge clk);
    vblank = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int nb0, nc0, nw0, n;
    for (int i = 0; i < 4096; i++) rom[i] = 8'd0;
    for (int i = 0; i < 2048; i++) begin
      ram[i] = 8'd0;
      bram[i] = 8'd0;
    end
    rom[12'h300] = 8'd2;  rom[12'h301] = 8'd5;  rom[12'h302] = "H"; rom[12'h303] = "I";
    rom[12'h400] = 8'd31; rom[12'h401] = 8'd31; rom[12'h402] = "A"; rom[12'h403] = "B";
    rom[12'h102] = "Z";
    for (int i = 2; i < 256; i++) rom[12'h500 + 12'(i)] = 8'(8'h41 + i % 26);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_osd", 32'(osd_active), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_data", 32'(ram_data), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    // message 3: clear, then "HI" at row 2 col 5, shown for 180 frames
    nb0 = n_blank; nc0 = n_char;
    send(4'd3);
    @(negedge clk);
    chk("a_busy", 32'(busy), 1);
    chk("a_osd_low", 32'(osd_active), 0);
    wait_osd(1'b1, "a_show");
    chk("a_blanks", 32'(n_blank - nb0), 1024);
    chk("a_chars", 32'(n_char - nc0), 2);
    chk("a_order", 32'(bad_order), 0);
    chk("a_ram69", 32'(ram[69]), 32'h48);
    chk("a_ram70", 32'(ram[70]), 32'h49);
    chk("a_ram71", 32'(ram[71]), 32'h20);
    repeat (179) vb_pulse();
    chk("a_osd_179", 32'(osd_active), 1);
    vb_pulse();
    chk("a_osd_180", 32'(osd_active), 0);
    chk("a_busy_180", 32'(busy), 0);
    // message 4: cursor wraps from the last cell to cell 0
    nc0 = n_char;
    send(4'd4);
    wait_osd(1'b1, "b_show");
    chk("b_chars", 32'(n_char - nc0), 2);
    chk("b_ram1023", 32'(ram[1023]), 32'h41);
    chk("b_ram0", 32'(ram[0]), 32'h42);
    // message 5 accepted from SHOW; a request raised during COPY is refused
    nc0 = n_char;
    send(4'd5);
    @(negedge clk);
    chk("c_osd_low", 32'(osd_active), 0);
    wait_char(nc0);
    req_valid = 1'b1;
    req_msg_id = 4'd1;
    for (int i = 0; i < 4; i++) begin
      chk("c_ready_copy", 32'(req_ready), 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("c_busy_copy", 32'(busy), 1);
    wait_osd(1'b1, "c_show");
    chk("c_chars", 32'(n_char - nc0), 254);
    chk("c_ram0", 32'(ram[0]), 32'h43);
    chk("c_ram253", 32'(ram[253]), 32'h56);
    chk("c_ram254", 32'(ram[254]), 32'h20);
    // message 1 from SHOW restarts the clear at address 0
    send(4'd1);
    @(negedge clk);
    chk("d_we", 32'(ram_we), 1);
    chk("d_addr0", 32'(ram_addr), 0);
    chk("d_blank", 32'(ram_data), 32'h20);
    n = 0;
    while (!(ram_we === 1'b1 && ram_addr === 11'd500) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("d_at500", 32'(ram_addr), 500);
    cancel = 1'b1;
    req_valid = 1'b1;
    req_msg_id = 4'd3;
    #1 chk("d_ready_cancel", 32'(req_ready), 0);
    @(posedge clk);
    #1 cancel = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("d_busy", 32'(busy), 0);
    chk("d_we_off", 32'(ram_we), 0);
    nw0 = nw;
    repeat (5) @(negedge clk);
    chk("d_no_writes", 32'(nw - nw0), 0);
    chk("d_not_accepted", 32'(busy), 0);
    // asynchronous reset in the middle of COPY
    nc0 = n_char;
    send(4'd5);
    wait_char(nc0);
    #2 reset = 1'b1;
    #1;
    chk("e_we", 32'(ram_we), 0);
    chk("e_busy", 32'(busy), 0);
    chk("e_osd", 32'(osd_active), 0);
    chk("e_rom_addr", 32'(rom_addr), 0);
    chk("e_ram_addr", 32'(ram_addr), 0);
    chk("e_ram_data", 32'(ram_data), 0);
    nw0 = nw;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("e_no_writes", 32'(nw - nw0), 0);
    chk("e_ready", 32'(req_ready), 1);
    // 4x4 screen, no frame limit: row 2 col 1 -> cells 9,10; stays shown until cancel
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_msg_id = 4'd3;
    @(posedge clk);
    #1 b_req_valid = 1'b0;
    n = 0;
    while (b_osd_active !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("f_show", 32'(b_osd_active), 1);
    chk("f_writes", 32'(b_nw), 18);
    chk("f_ram9", 32'(bram[9]), 32'h48);
    chk("f_ram10", 32'(bram[10]), 32'h49);
    chk("f_ram11", 32'(bram[11]), 32'h20);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      b_vblank = 1'b1;
      @(negedge clk);
      b_vblank = 1'b0;
    end
    chk("f_osd_1000", 32'(b_osd_active), 1);
    chk("f_busy_1000", 32'(b_busy), 1);
    b_cancel = 1'b1;
    @(negedge clk);
    b_cancel = 1'b0;
    chk("f_osd_cancel", 32'(b_osd_active), 0);
    chk("f_busy_cancel", 32'(b_busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
